tpu_host_seq: RTL and testbench
===============================

# tpu_host_seq

Host-side command sequencer that sits directly upstream of the TPU's memory-mapped port (clk, rst_n, r_w, addr, dataIn, dataOut). On a start pulse it streams one A matrix (DIM rows) and one B matrix (DIM rows) from a ready/valid input stream into the TPU, issues the compute kick, waits a fixed number of cycles, then reads every C row back out and presents it on a ready/valid output stream. It is the only master of the TPU bus; everything between start and done is sequenced here.

## Interface
- BITS_AB, 8, A/B element width
- BITS_C, 16, C element width
- DIM, 8, array dimension (rows of A, B, C)
- ADDRW, 16, TPU address width
- DATAW, 64, bus/stream word width; DIM*BITS_AB must equal DATAW
- WAIT_CYC, 22, cycles between kick write and first C read (3*DIM-2)

- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle request to run one matrix job
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse after last C word handed off
- in_valid  in  1  input word valid
- in_data  in  DATAW  A rows then B rows, row 0 first
- in_ready  out  1  sequencer accepts in_data this cycle
- out_valid  out  1  C word valid
- out_data  out  DATAW  C word
- out_ready  in  1  downstream accepts out_data
- r_w  out  1  TPU bus direction, 0 read, 1 write
- addr  out  ADDRW  TPU bus address
- tpu_din  out  DATAW  drives TPU dataIn
- tpu_dout  in  DATAW  from TPU dataOut

## Operation
- Address map: A row r at 0x0100+8r; B row r at 0x0200+8r; C row r word h at 0x0300+16r+8h, h in 0..CW-1, CW=DIM*BITS_C/DATAW (2 at defaults); compute kick = write of any data to 0x0400.
- States: IDLE, LOAD_A, LOAD_B, KICK, WAIT, RD_ISSUE, RD_CAP, RD_HOLD, DONE.
- IDLE: busy=0, in_ready=0. start=1 -> LOAD_A, row counter=0. start while busy ignored (no queueing).
- LOAD_A: in_ready=1. On in_valid&in_ready: r_w=1, addr=0x0100+8*cnt, tpu_din=in_data that same cycle (combinational pass-through of accepted word); cnt++. After row DIM-1 -> LOAD_B, cnt=0. No write when in_valid=0.
- LOAD_B: identical with base 0x0200; after row DIM-1 -> KICK.
- KICK: one cycle, r_w=1, addr=0x0400, tpu_din=0; wait counter=0 -> WAIT.
- WAIT: r_w=0; counts WAIT_CYC cycles, then RD_ISSUE with word index w=0.
- RD_ISSUE: r_w=0, addr=C address of w -> RD_CAP.
- RD_CAP: captures tpu_dout into out_data register, out_valid=1 -> RD_HOLD.
- RD_HOLD: holds out_data/out_valid until out_ready; on handshake out_valid=0; if w=DIM*CW-1 -> DONE else w++ -> RD_ISSUE.
- DONE: done=1 one cycle, busy=0 next -> IDLE.
- Counters sized for DIM*CW-1 and WAIT_CYC; no wrap within a job.

## Timing
- Reset (async assert, sync-safe deassert): state IDLE; busy=0, done=0, in_ready=0, out_valid=0, out_data=0, r_w=0, addr=0, tpu_din=0.
- Reset mid-job aborts immediately; no partial write completes after rst_n falls; next start begins a fresh job.
- Outside write cycles r_w=0 and tpu_din=0; addr=0 except in RD_ISSUE.
- TPU read latency: data on tpu_dout is sampled in the cycle after the address cycle.
- Minimum job latency (no stalls, defaults): start -> 1 + 8 + 8 + 1 + 22 + 16*3 cycles -> done; out_valid rises 3 cycles apart per word with out_ready=1.
- out_data stable while out_valid=1 and out_ready=0.
- busy rises the cycle after start is sampled; done and busy=0 never overlap with out_valid=1.

## Test plan
- Full job, A=identity (row r has 0x01 in byte r), B row r = bytes {r,r+1,...}: exactly 8 writes to 0x0100.., 8 to 0x0200.., one to 0x0400, then 16 reads 0x0300..0x0378 in order; out words equal model tpu_dout values; done pulses once.
- in_valid toggled randomly: no TPU write on cycles with in_valid=0; write count and row order unchanged.
- out_ready held low 10 cycles on word 5: out_data/out_valid stable, no further reads issued, resumes correctly.
- start pulsed during LOAD_B and WAIT: ignored, single job, single done.
- rst_n dropped mid LOAD_B (row 3): all outputs reset values immediately; following start rewrites A from row 0.
- WAIT length: first C read address appears exactly WAIT_CYC+1 cycles after kick write.

Source files
------------

// File: rtl/tpu_host_seq.sv
// Host-side command sequencer for the TPU memory-mapped port.
// Loads A and B rows, kicks compute, waits, then streams C rows out.
module tpu_host_seq #(
    parameter int BITS_AB  = 8,
    parameter int BITS_C   = 16,
    parameter int DIM      = 8,
    parameter int ADDRW    = 16,
    parameter int DATAW    = 64,
    parameter int WAIT_CYC = 22
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             busy,
    output logic             done,
    input  logic             in_valid,
    input  logic [DATAW-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [DATAW-1:0] out_data,
    input  logic             out_ready,
    output logic             r_w,
    output logic [ADDRW-1:0] addr,
    output logic [DATAW-1:0] tpu_din,
    input  logic [DATAW-1:0] tpu_dout
);

    localparam int CW        = DIM * BITS_C / DATAW;
    localparam int NWORDS    = DIM * CW;
    localparam int ROW_BYTES = DIM * BITS_AB / 8;
    localparam int WORD_B    = DATAW / 8;
    localparam int CROW_B    = CW * WORD_B;
    localparam int CMAX      = (NWORDS > WAIT_CYC) ? NWORDS : WAIT_CYC;
    localparam int CNTW      = $clog2(CMAX + 1);

    localparam logic [ADDRW-1:0] A_BASE = ADDRW'(16'h0100);
    localparam logic [ADDRW-1:0] B_BASE = ADDRW'(16'h0200);
    localparam logic [ADDRW-1:0] C_BASE = ADDRW'(16'h0300);
    localparam logic [ADDRW-1:0] K_ADDR = ADDRW'(16'h0400);

    typedef enum logic [3:0] {
        S_IDLE,
        S_LOAD_A,
        S_LOAD_B,
        S_KICK,
        S_WAIT,
        S_RD_ISSUE,
        S_RD_CAP,
        S_RD_HOLD,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNTW-1:0]  r_cnt;
    logic [CNTW-1:0]  w_cnt_nxt;
    logic [DATAW-1:0] r_out_data;
    logic             w_cap;
    logic [CNTW-1:0]  w_crow;
    logic [CNTW-1:0]  w_chalf;
    logic [ADDRW-1:0] w_row_off;
    logic [ADDRW-1:0] w_c_addr;

    // C word index splits into row and half-word within the row
    assign w_crow    = r_cnt / CNTW'(CW);
    assign w_chalf   = r_cnt % CNTW'(CW);
    assign w_row_off = ADDRW'(r_cnt) * ADDRW'(ROW_BYTES);
    assign w_c_addr  = C_BASE
                     + ADDRW'(w_crow) * ADDRW'(CROW_B)
                     + ADDRW'(w_chalf) * ADDRW'(WORD_B);

    assign busy      = (r_state != S_IDLE);
    assign out_valid = (r_state == S_RD_HOLD);
    assign out_data  = r_out_data;

    // State and shared row/wait/word counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // C word capture, one cycle after the read address cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_data <= '0;
        end else if (w_cap) begin
            r_out_data <= tpu_dout;
        end
    end

    // Next state, counter update and TPU bus drive
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_cap       = 1'b0;
        in_ready    = 1'b0;
        r_w         = 1'b0;
        addr        = '0;
        tpu_din     = '0;
        done        = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_LOAD_A;
                    w_cnt_nxt   = '0;
                end
            end
            S_LOAD_A: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    r_w     = 1'b1;
                    addr    = A_BASE + w_row_off;
                    tpu_din = in_data;
                    if (r_cnt == CNTW'(DIM - 1)) begin
                        w_state_nxt = S_LOAD_B;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + CNTW'(1);
                    end
                end
            end
            S_LOAD_B: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    r_w     = 1'b1;
                    addr    = B_BASE + w_row_off;
                    tpu_din = in_data;
                    if (r_cnt == CNTW'(DIM - 1)) begin
                        w_state_nxt = S_KICK;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + CNTW'(1);
                    end
                end
            end
            S_KICK: begin
                r_w         = 1'b1;
                addr        = K_ADDR;
                w_cnt_nxt   = '0;
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (r_cnt == CNTW'(WAIT_CYC - 1)) begin
                    w_state_nxt = S_RD_ISSUE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNTW'(1);
                end
            end
            S_RD_ISSUE: begin
                addr        = w_c_addr;
                w_state_nxt = S_RD_CAP;
            end
            S_RD_CAP: begin
                w_cap       = 1'b1;
                w_state_nxt = S_RD_HOLD;
            end
            S_RD_HOLD: begin
                if (out_ready) begin
                    if (r_cnt == CNTW'(NWORDS - 1)) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_cnt_nxt   = r_cnt + CNTW'(1);
                        w_state_nxt = S_RD_ISSUE;
                    end
                end
            end
            S_DONE: begin
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_tpu_host_seq.sv
// Directed bench for tpu_host_seq with a behavioural TPU read model.
// Bus activity is logged per cycle and compared to hand-derived sequences.
module tb_tpu_host_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [63:0] in_data = '0;
    logic [63:0] tpu_dout = '0;
    logic        busy, done, in_ready, out_valid, r_w;
    logic [63:0] out_data, tpu_din;
    logic [15:0] addr;

    tpu_host_seq dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .r_w(r_w), .addr(addr), .tpu_din(tpu_din), .tpu_dout(tpu_dout)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_fail = 0;
    int n_tot  = 0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] fc(input logic [15:0] a);
        return {16'hC0DE, a, ~a, a ^ 16'h5A5A};
    endfunction

    logic [63:0] vec [16];

    // TPU read model: data appears the cycle after the address cycle
    always @(posedge clk) begin
        if (!r_w && addr >= 16'h0300 && addr < 16'h0400)
            tpu_dout <= fc(addr);
    end

    logic [15:0] wa [$];
    logic [63:0] wd [$];
    logic [15:0] ra [$];
    int cyc = 0, kick_cyc = 0, first_rd = 0, start_cyc = 0, done_cyc = 0;
    int done_n = 0, bad_wr = 0, overlap = 0;
    bit kick_seen = 1'b0;
    bit clr = 1'b0;

    // Per-cycle bus logger
    always @(negedge clk) begin
        if (clr) begin
            wa.delete(); wd.delete(); ra.delete();
            kick_cyc <= 0; first_rd <= 0; start_cyc <= 0; done_cyc <= 0;
            done_n <= 0; bad_wr <= 0; overlap <= 0; kick_seen <= 1'b0;
        end else if (rst_n) begin
            if (r_w) begin
                wa.push_back(addr);
                wd.push_back(tpu_din);
                if (addr == 16'h0400) begin
                    kick_cyc <= cyc;
                    kick_seen <= 1'b1;
                end else if (!(in_valid && in_ready) || tpu_din !== in_data) begin
                    bad_wr <= bad_wr + 1;
                end
            end else begin
                if (tpu_din != 64'd0) bad_wr <= bad_wr + 1;
                if (addr != 16'd0) begin
                    if (ra.size() == 0) first_rd <= cyc;
                    ra.push_back(addr);
                end
            end
            if (start && !busy) start_cyc <= cyc;
            if (done) begin
                done_n <= done_n + 1;
                done_cyc <= cyc;
            end
            if ((done || !busy) && out_valid) overlap <= overlap + 1;
        end
        cyc <= cyc + 1;
    end

    task automatic clear_log();
        @(posedge clk); #1 clr = 1'b1;
        @(posedge clk); #1 clr = 1'b0;
    endtask

    task automatic chk_reset_outs(input string tg);
        chk({tg, "_busy"}, 64'(busy), 64'd0);
        chk({tg, "_done"}, 64'(done), 64'd0);
        chk({tg, "_in_ready"}, 64'(in_ready), 64'd0);
        chk({tg, "_out_valid"}, 64'(out_valid), 64'd0);
        chk({tg, "_out_data"}, out_data, 64'd0);
        chk({tg, "_r_w"}, 64'(r_w), 64'd0);
        chk({tg, "_addr"}, 64'(addr), 64'd0);
        chk({tg, "_tpu_din"}, tpu_din, 64'd0);
    endtask

    task automatic run_job(input bit rnd, input int stall_w, input bit extra,
                           input int abort_at);
        int ii = 0, oi = 0, n = 0, st = 0, rd0 = 0, sbad = 0;
        bit s1 = 1'b0, s2 = 1'b0, fin = 1'b0;
        logic [63:0] held = '0;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        while (!fin && n < 3000) begin
            start = 1'b0;
            if (extra && !s1 && ii == 11) begin
                start = 1'b1;
                s1 = 1'b1;
            end else if (extra && !s2 && kick_seen && cyc >= kick_cyc + 5) begin
                start = 1'b1;
                s2 = 1'b1;
            end
            in_valid = (ii < 16) && (!rnd || $urandom_range(0, 1) == 1);
            in_data = (ii < 16) ? vec[ii] : 64'd0;
            out_ready = !(oi == stall_w && st < 10);
            if (abort_at >= 0 && ii == abort_at) begin
                in_valid = 1'b1;
                #1;
                chk("pre_rst_addr", 64'(addr), 64'h0218);
                chk("pre_rst_din", tpu_din, vec[ii]);
                rst_n = 1'b0;
                #1;
                chk_reset_outs("abort");
                @(negedge clk);
                in_valid = 1'b0;
                rst_n = 1'b1;
                fin = 1'b1;
            end else begin
                @(negedge clk);
                if (in_valid && in_ready) ii++;
                if (out_valid && !out_ready) begin
                    if (st == 0) begin
                        held = out_data;
                        rd0 = ra.size();
                    end else if (out_data !== held) begin
                        sbad++;
                    end
                    st++;
                end else if (out_valid) begin
                    chk($sformatf("out_data_w%0d", oi), out_data,
                        fc(16'(16'h0300 + 8 * oi)));
                    if (oi == stall_w) begin
                        chk("stall_len", 64'(st), 64'd10);
                        chk("stall_hold", out_data, held);
                        chk("stall_no_rd", 64'(ra.size()), 64'(rd0));
                    end
                    oi++;
                end else if (oi == stall_w && st > 0 && st < 10) begin
                    sbad++;
                end
                if (done) fin = 1'b1;
                @(posedge clk); #1;
            end
            n++;
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        start = 1'b0;
        chk("job_timeout", 64'(fin), 64'd1);
        if (stall_w >= 0) chk("stall_stable", 64'(sbad), 64'd0);
        if (abort_at < 0) chk("out_count", 64'(oi), 64'd16);
    endtask

    task automatic check_job(input string tg);
        chk({tg, "_nwr"}, 64'(wa.size()), 64'd17);
        if (wa.size() == 17) begin
            for (int r = 0; r < 8; r++) begin
                chk($sformatf("%s_a_addr%0d", tg, r), 64'(wa[r]), 64'(16'h0100 + 8 * r));
                chk($sformatf("%s_a_data%0d", tg, r), wd[r], vec[r]);
                chk($sformatf("%s_b_addr%0d", tg, r), 64'(wa[8 + r]), 64'(16'h0200 + 8 * r));
                chk($sformatf("%s_b_data%0d", tg, r), wd[8 + r], vec[8 + r]);
            end
            chk({tg, "_kick_addr"}, 64'(wa[16]), 64'h0400);
            chk({tg, "_kick_data"}, wd[16], 64'd0);
        end
        chk({tg, "_nrd"}, 64'(ra.size()), 64'd16);
        if (ra.size() == 16) begin
            for (int k = 0; k < 16; k++)
                chk($sformatf("%s_rd_addr%0d", tg, k), 64'(ra[k]), 64'(16'h0300 + 8 * k));
        end
        chk({tg, "_done_n"}, 64'(done_n), 64'd1);
        chk({tg, "_wait_len"}, 64'(first_rd - kick_cyc), 64'd23);
        chk({tg, "_bad_wr"}, 64'(bad_wr), 64'd0);
        chk({tg, "_overlap"}, 64'(overlap), 64'd0);
    endtask

    initial begin
        for (int r = 0; r < 8; r++) begin
            vec[r] = 64'd1 << (8 * r);
            vec[8 + r] = '0;
            for (int j = 0; j < 8; j++)
                vec[8 + r][8 * j +: 8] = 8'(r + j);
        end

        // Reset state
        #1;
        chk_reset_outs("rst");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        clear_log();

        // Job 1: no stalls, full-rate input, exact latency
        run_job(1'b0, -1, 1'b0, -1);
        check_job("j1");
        chk("j1_latency", 64'(done_cyc - start_cyc), 64'd88);
        chk("j1_busy_after", 64'(busy), 64'd0);

        // Job 2: random in_valid, stall on word 5, stray starts
        clear_log();
        run_job(1'b1, 5, 1'b1, -1);
        repeat (100) @(posedge clk);
        #1;
        check_job("j2");

        // Job 3: reset while writing B row 3, then a fresh job
        clear_log();
        run_job(1'b0, -1, 1'b0, 11);
        @(posedge clk); #1;
        chk("post_abort_busy", 64'(busy), 64'd0);
        clear_log();
        run_job(1'b0, -1, 1'b0, -1);
        check_job("j3");
        chk("j3_latency", 64'(done_cyc - start_cyc), 64'd88);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
